bv_responder: RTL
=================

BV_RESPONDER -- requirements
Module: bv_responder

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h03, the device address this responder answers.
REQ-002 SHALL have parameter MAX_LNG, default 16, the largest accepted frame length in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, the inter-byte timeout (5 ms at 10 MHz).
REQ-004 SHALL have port CLK_10MHZ  in  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port rx_data  in  8  received byte, valid only while rx_valid=1.
REQ-007 SHALL have port rx_valid  in  1  one-cycle strobe per received byte.
REQ-008 SHALL have port tx_data  out  8  byte to transmit, held stable from tx_start until the next tx_start.
REQ-009 SHALL have port tx_start  out  1  one-cycle strobe launching tx_data.
REQ-010 SHALL have port tx_busy  in  1  UART transmitter busy.
REQ-011 SHALL have port status_code  in  8  current device state code (e.g. 8'h14 idling, 8'h19 disabled).
REQ-012 SHALL have port bill_stacked  in  1  one-cycle bill-stacked event.
REQ-013 SHALL have port bill_type  in  8  bill type, sampled with bill_stacked.
REQ-014 SHALL have port reset_req  out  1  one-cycle pulse on an accepted RESET command.
REQ-015 SHALL have port poll_seen  out  1  one-cycle pulse on an accepted POLL command.
REQ-016 SHALL have port bill_pending  out  1  a stacked-bill event awaits host acknowledgement.
REQ-017 SHALL have port crc_err_cnt  out  8  count of CRC failures, saturating at 8'hFF.

Function
REQ-018 SHALL parse frames as SYNC 8'h02, ADR, LNG, CMD, DATA[LNG-6], CRC_L, CRC_H, with LNG the total byte count.
REQ-019 SHALL compute CRC as CRC16 with reflected polynomial 16'h8408 and init 16'h0000, over SYNC..last DATA byte, and SHALL transmit/check it LSB first.
REQ-020 SHALL use receive FSM states IDLE -> ADDR -> LEN -> BODY -> CHECK, followed by send state SEND and a return to IDLE.
REQ-021 In IDLE, SHALL ignore every byte except 8'h02.
REQ-022 SHALL abort to IDLE without reply when ADR != DEV_ADDR, or when LNG < 6 or LNG > MAX_LNG.
REQ-023 SHALL abort to IDLE without reply and without counting when more than TIMEOUT_CYC cycles elapse between bytes in ADDR, LEN or BODY.
REQ-024 On a CRC mismatch, SHALL increment crc_err_cnt (saturating) and reply with NAK frame 02 ADR 06 FF CRC.
REQ-025 On a good POLL (CMD 8'h33), SHALL pulse poll_seen and reply as follows: if bill_pending=0, with 02 ADR 06 status_code CRC; if bill_pending=1, with 02 ADR 07 81 bill_type_latched CRC, and SHALL set the reported flag.
REQ-026 On a good ACK (CMD 8'h00), SHALL send no reply; if the reported flag is set, SHALL clear bill_pending and the reported flag.
REQ-027 On a good RESET (CMD 8'h30), SHALL pulse reset_req, clear bill_pending and the reported flag, and reply with ACK 02 ADR 06 00 CRC.
REQ-028 On any other good command, SHALL reply with ILLEGAL COMMAND frame 02 ADR 06 30 CRC.
REQ-029 In CHECK, SHALL decide within 1 cycle of the CRC_H byte; the first tx_start SHALL occur no later than 2 cycles after that decision.
REQ-030 SHALL pulse tx_start only when tx_busy=0, and SHALL issue the next byte only after observing tx_busy high and then low again.
REQ-031 SHALL accumulate the transmit CRC during SEND, append it LSB then MSB, and return to IDLE after the last byte's busy falls.
REQ-032 SHALL ignore rx_valid during SEND (half-duplex).
REQ-033 When bill_stacked=1 and bill_pending=0, SHALL set bill_pending and latch bill_type; when bill_stacked=1 while bill_pending=1, SHALL drop the event.
REQ-034 When bill_stacked coincides with a clearing ACK, SHALL apply the clear first and then latch the new event.

Reset
REQ-035 RST_N=0 SHALL force IDLE and tx_start=0, tx_data=0, reset_req=0, poll_seen=0, bill_pending=0, reported=0, crc_err_cnt=0, timeout counter=0.
REQ-036 Reset mid-frame or mid-SEND SHALL abandon the frame with no further tx_start.

Structure
REQ-037 SHALL take the SYNC, command/response codes (33, 30, 00, FF, 81), and FSM state encodings from a shared package ccnet_pkg.
REQ-038 SHALL contain one sub-module, ccnet_crc16: a one-cycle byte-wise update with clear and enable, instanced twice (rx, tx).

Verification
REQ-039 SHALL cover: RESET frame 02 03 06 30 + CRC -> reset_req pulse, reply 02 03 06 00 C2 82.
REQ-040 SHALL cover: POLL 02 03 06 33 DA 81 with status_code=8'h14 -> poll_seen, reply 02 03 06 14 + model CRC.
REQ-041 SHALL cover: POLL 02 03 06 33 DA 80 -> crc_err_cnt=1, NAK 02 03 06 FF + model CRC.
REQ-042 SHALL cover: POLL with ADR 8'h05, and separately 02 03 followed by TIMEOUT_CYC+1 idle cycles and then a valid POLL -> no tx for the first, normal reply for the valid POLL.
REQ-043 SHALL cover: bill_stacked with type 8'h02, then POLL -> 02 03 07 81 02 + CRC; then host ACK 02 03 06 00 C2 82 -> bill_pending=0; then next POLL -> status frame.
REQ-044 SHALL cover: a second bill_stacked while pending -> dropped, and bill_stacked in the same cycle as a clearing ACK -> bill_pending=1 with the new type.

Source files
------------

// File: rtl/ccnet_pkg.sv
// rtl/ccnet_pkg.sv - CCNET framing constants, FSM encodings and CRC16 byte step
package ccnet_pkg;

  localparam logic [7:0] SYNC        = 8'h02;
  localparam logic [7:0] CMD_POLL    = 8'h33;
  localparam logic [7:0] CMD_RESET   = 8'h30;
  localparam logic [7:0] CMD_ACK     = 8'h00;
  localparam logic [7:0] RSP_ACK     = 8'h00;
  localparam logic [7:0] RSP_NAK     = 8'hFF;
  localparam logic [7:0] RSP_BILL    = 8'h81;
  localparam logic [7:0] RSP_ILLEGAL = 8'h30;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_LEN   = 3'd2;
  localparam logic [2:0] ST_BODY  = 3'd3;
  localparam logic [2:0] ST_CHECK = 3'd4;
  localparam logic [2:0] ST_SEND  = 3'd5;

  localparam logic [1:0] TX_ISSUE     = 2'd0;
  localparam logic [1:0] TX_WAIT_HIGH = 2'd1;
  localparam logic [1:0] TX_WAIT_LOW  = 2'd2;

  // Reflected CRC16 (poly 0x8408), one byte, LSB-first bit order
  function automatic logic [15:0] crc16Byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/ccnet_crc16.sv
// rtl/ccnet_crc16.sv - byte-wise CCNET CRC16 accumulator with clear and enable
// clr together with en restarts the CRC from zero with the presented byte.
module ccnet_crc16
  import ccnet_pkg::*;
(
  input  logic        CLK_10MHZ,
  input  logic        RST_N,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  always_ff @(posedge CLK_10MHZ) begin
    if (!RST_N) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= crc16Byte(clr ? 16'h0000 : crc, data);
    end else if (clr) begin
      crc <= 16'h0000;
    end
  end

endmodule

// File: rtl/bv_responder.sv
// rtl/bv_responder.sv - CCNET bill validator responder: frame parse, CRC check, reply
// Half-duplex: receive FSM hands over to SEND, which paces bytes on tx_busy edges.
module bv_responder
  import ccnet_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR    = 8'h03,
  parameter int         MAX_LNG     = 16,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       CLK_10MHZ,
  input  logic       RST_N,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic [7:0] status_code,
  input  logic       bill_stacked,
  input  logic [7:0] bill_type,
  output logic       reset_req,
  output logic       poll_seen,
  output logic       bill_pending,
  output logic [7:0] crc_err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]      state;
  logic [1:0]      txPhase;
  logic [7:0]      byteCnt, frameLng, cmd, crcRxL, crcRxH;
  logic [TO_W-1:0] toCnt;
  logic [7:0]      rspLng, rspB3, rspB4, txByte, billTypeLatched;
  logic [2:0]      txIdx, txLen;
  logic            reported;
  logic [15:0]     rxCrc, txCrc;
  logic            syncHit, rxCrcEn, txIssue, crcOk, goodPoll, goodAck, goodReset, clearBill;

  assign syncHit   = (state == ST_IDLE) && rx_valid && (rx_data == SYNC);
  assign rxCrcEn   = syncHit || (rx_valid && ((state == ST_ADDR) || (state == ST_LEN) ||
                     ((state == ST_BODY) && (byteCnt < frameLng - 8'd2))));
  assign txLen     = rspLng[2:0] - 3'd2;
  assign txIssue   = (state == ST_SEND) && (txPhase == TX_ISSUE) && !tx_busy;
  assign crcOk     = (rxCrc == {crcRxH, crcRxL});
  assign goodPoll  = (state == ST_CHECK) && crcOk && (cmd == CMD_POLL);
  assign goodAck   = (state == ST_CHECK) && crcOk && (cmd == CMD_ACK);
  assign goodReset = (state == ST_CHECK) && crcOk && (cmd == CMD_RESET);
  assign clearBill = goodReset || (goodAck && reported);

  always_comb begin
    txByte = 8'h00;
    if (txIdx < txLen) begin
      case (txIdx)
        3'd0:    txByte = SYNC;
        3'd1:    txByte = DEV_ADDR;
        3'd2:    txByte = rspLng;
        3'd3:    txByte = rspB3;
        default: txByte = rspB4;
      endcase
    end else if (txIdx == txLen) begin
      txByte = txCrc[7:0];
    end else begin
      txByte = txCrc[15:8];
    end
  end

  ccnet_crc16 uRxCrc (
    .CLK_10MHZ(CLK_10MHZ), .RST_N(RST_N),
    .clr(state == ST_IDLE), .en(rxCrcEn), .data(rx_data), .crc(rxCrc)
  );

  ccnet_crc16 uTxCrc (
    .CLK_10MHZ(CLK_10MHZ), .RST_N(RST_N),
    .clr(state != ST_SEND), .en(txIssue && (txIdx < txLen)), .data(txByte), .crc(txCrc)
  );

  always_ff @(posedge CLK_10MHZ) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      txPhase     <= TX_ISSUE;
      byteCnt     <= 8'h00;
      frameLng    <= 8'h00;
      cmd         <= 8'h00;
      crcRxL      <= 8'h00;
      crcRxH      <= 8'h00;
      toCnt       <= '0;
      rspLng      <= 8'h06;
      rspB3       <= 8'h00;
      rspB4       <= 8'h00;
      txIdx       <= 3'd0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
      reset_req   <= 1'b0;
      poll_seen   <= 1'b0;
      crc_err_cnt <= 8'h00;
    end else begin
      tx_start  <= 1'b0;
      reset_req <= 1'b0;
      poll_seen <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (syncHit) begin
            state   <= ST_ADDR;
            byteCnt <= 8'd1;
            toCnt   <= '0;
          end
        end
        ST_ADDR, ST_LEN, ST_BODY: begin
          if (rx_valid) begin
            toCnt   <= '0;
            byteCnt <= byteCnt + 8'd1;
            if (state == ST_ADDR) begin
              state <= (rx_data == DEV_ADDR) ? ST_LEN : ST_IDLE;
            end else if (state == ST_LEN) begin
              frameLng <= rx_data;
              state    <= ((rx_data < 8'd6) || (rx_data > 8'(MAX_LNG))) ? ST_IDLE : ST_BODY;
            end else begin
              if (byteCnt == 8'd3) cmd <= rx_data;
              if (byteCnt == frameLng - 8'd2) crcRxL <= rx_data;
              if (byteCnt == frameLng - 8'd1) begin
                crcRxH <= rx_data;
                state  <= ST_CHECK;
              end
            end
          end else if (toCnt == TO_W'(TIMEOUT_CYC)) begin
            state <= ST_IDLE;
            toCnt <= '0;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        ST_CHECK: begin
          txIdx   <= 3'd0;
          txPhase <= TX_ISSUE;
          rspLng  <= 8'h06;
          state   <= ST_SEND;
          if (!crcOk) begin
            if (crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;
            rspB3 <= RSP_NAK;
          end else begin
            case (cmd)
              CMD_POLL: begin
                poll_seen <= 1'b1;
                if (bill_pending) begin
                  rspLng <= 8'h07;
                  rspB3  <= RSP_BILL;
                  rspB4  <= billTypeLatched;
                end else begin
                  rspB3 <= status_code;
                end
              end
              CMD_ACK:   state <= ST_IDLE;
              CMD_RESET: begin
                reset_req <= 1'b1;
                rspB3     <= RSP_ACK;
              end
              default:   rspB3 <= RSP_ILLEGAL;
            endcase
          end
        end
        ST_SEND: begin
          case (txPhase)
            TX_ISSUE: begin
              if (!tx_busy) begin
                tx_start <= 1'b1;
                tx_data  <= txByte;
                txPhase  <= TX_WAIT_HIGH;
              end
            end
            TX_WAIT_HIGH: if (tx_busy) txPhase <= TX_WAIT_LOW;
            default: begin
              if (!tx_busy) begin
                if (txIdx == txLen + 3'd1) begin
                  state <= ST_IDLE;
                end else begin
                  txIdx   <= txIdx + 3'd1;
                  txPhase <= TX_ISSUE;
                end
              end
            end
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Clear from ACK/RESET is applied before a coincident stacked-bill event latches
  always_ff @(posedge CLK_10MHZ) begin
    if (!RST_N) begin
      bill_pending    <= 1'b0;
      reported        <= 1'b0;
      billTypeLatched <= 8'h00;
    end else begin
      if (clearBill) begin
        bill_pending <= 1'b0;
        reported     <= 1'b0;
      end else if (goodPoll && bill_pending) begin
        reported <= 1'b1;
      end
      if (bill_stacked && (!bill_pending || clearBill)) begin
        bill_pending    <= 1'b1;
        billTypeLatched <= bill_type;
      end
    end
  end

endmodule
